// File: rtl/sequencer_pkg.sv
// Shared opcodes, step encodings, instruction classes and control bundle
// for the Mini-SRC control sequencer.
package sequencer_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [3:0] S_T0   = 4'd0;
  localparam logic [3:0] S_T1   = 4'd1;
  localparam logic [3:0] S_T2   = 4'd2;
  localparam logic [3:0] S_T3   = 4'd3;
  localparam logic [3:0] S_T4   = 4'd4;
  localparam logic [3:0] S_T5   = 4'd5;
  localparam logic [3:0] S_T6   = 4'd6;
  localparam logic [3:0] S_T7   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  typedef enum logic [3:0] {
    CL_RR, CL_IMM, CL_MULDIV, CL_UNARY,
    CL_LD, CL_LDI, CL_ST, CL_BR, CL_JR,
    CL_IN, CL_OUT, CL_MFHI, CL_MFLO,
    CL_NOP, CL_HALT
  } iclass_t;

  typedef struct packed {
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic hi_in;
    logic lo_in;
    logic hi_out;
    logic lo_out;
    logic con_in;
    logic inport_out;
    logic outport_in;
    logic read;
    logic write;
  } ctrl_t;

  // Final execute step of each class; after it the sequencer refetches.
  function automatic logic [3:0] last_step(iclass_t c);
    logic [3:0] s;
    s = S_T3;
    case (c)
      CL_RR, CL_IMM, CL_LDI: s = S_T5;
      CL_MULDIV, CL_BR:      s = S_T6;
      CL_UNARY:              s = S_T4;
      CL_LD, CL_ST:          s = S_T7;
      default:               s = S_T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_opcode_classifier.sv
// Combinational opcode-to-instruction-class map.
// Unlisted opcodes (including jal and 28-31) execute as nop.
module opcode_classifier
  import sequencer_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_t    class_o
);

  always_comb begin
    class_o = CL_NOP;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: class_o = CL_RR;
      OP_ADDI, OP_ANDI, OP_ORI:        class_o = CL_IMM;
      OP_MUL, OP_DIV:                  class_o = CL_MULDIV;
      OP_NEG, OP_NOT:                  class_o = CL_UNARY;
      OP_LD:                           class_o = CL_LD;
      OP_LDI:                          class_o = CL_LDI;
      OP_ST:                           class_o = CL_ST;
      OP_BR:                           class_o = CL_BR;
      OP_JR:                           class_o = CL_JR;
      OP_IN:                           class_o = CL_IN;
      OP_OUT:                          class_o = CL_OUT;
      OP_MFHI:                         class_o = CL_MFHI;
      OP_MFLO:                         class_o = CL_MFLO;
      OP_HALT:                         class_o = CL_HALT;
      default:                         class_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore step sequencer for the Mini-SRC datapath: fetch T0-T2,
// execute T3-T7, memory-handshake stalls and HALT.
module control_sequencer
  import sequencer_pkg::*;
#(
  parameter int OPW   = 5,
  parameter int STEPW = 3
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  input  logic           mem_done,
  output logic           run,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           r_in,
  output logic           r_out,
  output logic           ba_out,
  output logic           c_out,
  output logic           pc_out,
  output logic           pc_in,
  output logic           inc_pc,
  output logic           mar_in,
  output logic           mdr_in,
  output logic           mdr_out,
  output logic           ir_in,
  output logic           y_in,
  output logic           z_in,
  output logic           zlow_out,
  output logic           zhigh_out,
  output logic           hi_in,
  output logic           lo_in,
  output logic           hi_out,
  output logic           lo_out,
  output logic           con_in,
  output logic           inport_out,
  output logic           outport_in,
  output logic           read,
  output logic           write,
  output logic [OPW-1:0] alu_op
);

  localparam logic [STEPW:0] STEP_INC = 1;

  logic [STEPW:0] state_q, state_d;
  logic           run_q, run_d;
  logic [OPW-1:0] opcode;
  logic [26:0]    unused_ir;
  iclass_t        cls;
  ctrl_t          ctl;
  logic [OPW-1:0] alu;

  assign opcode    = ir[31 -: OPW];
  assign unused_ir = ir[26:0];

  opcode_classifier u_cls (
    .opcode_i (opcode),
    .class_o  (cls)
  );

  always_comb begin
    ctl = '0;
    alu = OP_ADD;
    case (state_q)
      S_T0: begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1;
        ctl.inc_pc = 1'b1; ctl.z_in   = 1'b1;
      end
      S_T1: begin
        ctl.zlow_out = 1'b1; ctl.pc_in  = 1'b1;
        ctl.read     = 1'b1; ctl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
      end
      S_T3: begin
        case (cls)
          CL_RR, CL_IMM: begin
            ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
            alu = opcode;
          end
          CL_MULDIV: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
          end
          CL_UNARY: begin
            ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1;
            alu = opcode;
          end
          CL_LD, CL_LDI, CL_ST: begin
            ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
          end
          CL_BR: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1;
          end
          CL_JR: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1;
          end
          CL_IN: begin
            ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          CL_OUT: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1;
          end
          CL_MFHI: begin
            ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          CL_MFLO: begin
            ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          CL_RR: begin
            ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1;
            alu = opcode;
          end
          CL_IMM: begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
            alu = opcode;
          end
          CL_MULDIV: begin
            ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1;
            alu = opcode;
          end
          CL_UNARY: begin
            ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          CL_LD, CL_LDI, CL_ST: begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
          end
          CL_BR: begin
            ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CL_RR, CL_IMM: begin
            ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
            alu = opcode;
          end
          CL_MULDIV: begin
            ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1;
          end
          CL_LD, CL_ST: begin
            ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1;
          end
          CL_LDI: begin
            ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          CL_BR: begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          CL_MULDIV: begin
            ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1;
          end
          CL_LD: begin
            ctl.read = 1'b1; ctl.mdr_in = 1'b1;
          end
          CL_ST: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1;
          end
          CL_BR: begin
            ctl.zlow_out = 1'b1; ctl.pc_in = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          CL_LD: begin
            ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          CL_ST: ctl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    // Reset and HALT force every control, alu_op included, to zero.
    if (!run_q) begin
      ctl = '0;
      alu = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (!run_q) begin
      if (state_q != S_HALT) begin
        state_d = S_T0;
        run_d   = 1'b1;
      end
    end else if ((ctl.read || ctl.write) && !mem_done) begin
      state_d = state_q;
    end else if (state_q == last_step(cls)) begin
      if (cls == CL_HALT) begin
        state_d = S_HALT;
        run_d   = 1'b0;
      end else begin
        state_d = S_T0;
      end
    end else begin
      state_d = state_q + STEP_INC;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_T0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign run        = run_q;
  assign alu_op     = alu;
  assign gra        = ctl.gra;
  assign grb        = ctl.grb;
  assign grc        = ctl.grc;
  assign r_in       = ctl.r_in;
  assign r_out      = ctl.r_out;
  assign ba_out     = ctl.ba_out;
  assign c_out      = ctl.c_out;
  assign pc_out     = ctl.pc_out;
  assign pc_in      = ctl.pc_in;
  assign inc_pc     = ctl.inc_pc;
  assign mar_in     = ctl.mar_in;
  assign mdr_in     = ctl.mdr_in;
  assign mdr_out    = ctl.mdr_out;
  assign ir_in      = ctl.ir_in;
  assign y_in       = ctl.y_in;
  assign z_in       = ctl.z_in;
  assign zlow_out   = ctl.zlow_out;
  assign zhigh_out  = ctl.zhigh_out;
  assign hi_in      = ctl.hi_in;
  assign lo_in      = ctl.lo_in;
  assign hi_out     = ctl.hi_out;
  assign lo_out     = ctl.lo_out;
  assign con_in     = ctl.con_in;
  assign inport_out = ctl.inport_out;
  assign outport_in = ctl.outport_in;
  assign read       = ctl.read;
  assign write      = ctl.write;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed cycle-by-cycle vectors for control_sequencer.
// Each vector holds the inputs for one cycle and the outputs expected then.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, con_ff, mem_done;
  logic [31:0] ir;
  logic        run, gra, grb, grc, r_in, r_out, ba_out, c_out;
  logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, hi_out;
  logic        lo_out, con_in, inport_out, outport_in, read, write;
  logic [4:0]  alu_op;
  logic [26:0] act;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
    .mem_done(mem_done), .run(run), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .c_out(c_out),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
    .con_in(con_in), .inport_out(inport_out), .outport_in(outport_in),
    .read(read), .write(write), .alu_op(alu_op)
  );

  assign act = {write, read, outport_in, inport_out, con_in, lo_out,
                hi_out, lo_in, hi_in, zhigh_out, zlow_out, z_in, y_in,
                ir_in, mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out,
                c_out, ba_out, r_out, r_in, grc, grb, gra};

  localparam logic [26:0] M_GRA   = 27'd1 << 0;
  localparam logic [26:0] M_GRB   = 27'd1 << 1;
  localparam logic [26:0] M_GRC   = 27'd1 << 2;
  localparam logic [26:0] M_RIN   = 27'd1 << 3;
  localparam logic [26:0] M_ROUT  = 27'd1 << 4;
  localparam logic [26:0] M_BAOUT = 27'd1 << 5;
  localparam logic [26:0] M_COUT  = 27'd1 << 6;
  localparam logic [26:0] M_PCOUT = 27'd1 << 7;
  localparam logic [26:0] M_PCIN  = 27'd1 << 8;
  localparam logic [26:0] M_INCPC = 27'd1 << 9;
  localparam logic [26:0] M_MARIN = 27'd1 << 10;
  localparam logic [26:0] M_MDRIN = 27'd1 << 11;
  localparam logic [26:0] M_MDROUT = 27'd1 << 12;
  localparam logic [26:0] M_IRIN  = 27'd1 << 13;
  localparam logic [26:0] M_YIN   = 27'd1 << 14;
  localparam logic [26:0] M_ZIN   = 27'd1 << 15;
  localparam logic [26:0] M_ZLO   = 27'd1 << 16;
  localparam logic [26:0] M_ZHI   = 27'd1 << 17;
  localparam logic [26:0] M_HIIN  = 27'd1 << 18;
  localparam logic [26:0] M_LOIN  = 27'd1 << 19;
  localparam logic [26:0] M_HIOUT = 27'd1 << 20;
  localparam logic [26:0] M_LOOUT = 27'd1 << 21;
  localparam logic [26:0] M_CONIN = 27'd1 << 22;
  localparam logic [26:0] M_INP   = 27'd1 << 23;
  localparam logic [26:0] M_OUTP  = 27'd1 << 24;
  localparam logic [26:0] M_READ  = 27'd1 << 25;
  localparam logic [26:0] M_WRITE = 27'd1 << 26;

  localparam logic [26:0] T0_C = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [26:0] T1_C = M_ZLO | M_PCIN | M_READ | M_MDRIN;
  localparam logic [26:0] T2_C = M_MDROUT | M_IRIN;
  localparam logic [4:0]  A_ADD = 5'd3;

  typedef struct {
    string       nm;
    logic        clr;
    logic [4:0]  op;
    logic        con;
    logic        md;
    logic        run;
    logic [26:0] ctl;
    logic [4:0]  alu;
  } vec_t;

  vec_t tv[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(string nm, logic clr, logic [4:0] op, logic con,
                      logic md, logic r, logic [26:0] ctl,
                      logic [4:0] alu);
    vec_t v;
    v.nm = nm; v.clr = clr; v.op = op; v.con = con; v.md = md;
    v.run = r; v.ctl = ctl; v.alu = alu;
    tv.push_back(v);
  endtask

  // Running fetch of one instruction: T0, T1, T2 with memory ready.
  task automatic fetch(string nm, logic [4:0] op);
    push({nm, "_t0"}, 0, op, 0, 1, 1, T0_C, A_ADD);
    push({nm, "_t1"}, 0, op, 0, 1, 1, T1_C, A_ADD);
    push({nm, "_t2"}, 0, op, 0, 1, 1, T2_C, A_ADD);
  endtask

  task automatic apply(vec_t v);
    clear    = v.clr;
    ir       = {v.op, 27'h2A5_1C3};
    con_ff   = v.con;
    mem_done = v.md;
    #1;
    tests++;
    if (run !== v.run || act !== v.ctl || alu_op !== v.alu) begin
      fails++;
      $display("FAIL %s: got run=%b ctl=%h alu=%0d, want run=%b ctl=%h alu=%0d",
               v.nm, run, act, alu_op, v.run, v.ctl, v.alu);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t hv;
    clear = 1'b1; ir = '0; con_ff = 1'b0; mem_done = 1'b1;

    push("rst0", 1, 5'd3, 0, 1, 0, '0, 5'd0);
    push("rst1", 1, 5'd3, 0, 1, 0, '0, 5'd0);
    push("rst_fall", 0, 5'd3, 0, 1, 0, '0, 5'd0);
    fetch("add", 5'd3);
    push("add_t3", 0, 5'd3, 0, 1, 1, M_GRB | M_ROUT | M_YIN, 5'd3);
    push("add_t4", 0, 5'd3, 0, 1, 1, M_GRC | M_ROUT | M_ZIN, 5'd3);
    push("add_t5", 0, 5'd3, 0, 1, 1, M_ZLO | M_GRA | M_RIN, 5'd3);
    fetch("sub", 5'd4);
    push("sub_t3", 0, 5'd4, 0, 1, 1, M_GRB | M_ROUT | M_YIN, 5'd4);
    push("sub_t4", 0, 5'd4, 0, 1, 1, M_GRC | M_ROUT | M_ZIN, 5'd4);
    push("sub_t5", 0, 5'd4, 0, 1, 1, M_ZLO | M_GRA | M_RIN, 5'd4);
    fetch("addi", 5'd12);
    push("addi_t3", 0, 5'd12, 0, 1, 1, M_GRB | M_ROUT | M_YIN, 5'd12);
    push("addi_t4", 0, 5'd12, 0, 1, 1, M_COUT | M_ZIN, 5'd12);
    push("addi_t5", 0, 5'd12, 0, 1, 1, M_ZLO | M_GRA | M_RIN, 5'd12);
    fetch("mul", 5'd15);
    push("mul_t3", 0, 5'd15, 0, 1, 1, M_GRA | M_ROUT | M_YIN, A_ADD);
    push("mul_t4", 0, 5'd15, 0, 1, 1, M_GRB | M_ROUT | M_ZIN, 5'd15);
    push("mul_t5", 0, 5'd15, 0, 1, 1, M_ZLO | M_LOIN, A_ADD);
    push("mul_t6", 0, 5'd15, 0, 1, 1, M_ZHI | M_HIIN, A_ADD);
    fetch("neg", 5'd17);
    push("neg_t3", 0, 5'd17, 0, 1, 1, M_GRB | M_ROUT | M_ZIN, 5'd17);
    push("neg_t4", 0, 5'd17, 0, 1, 1, M_ZLO | M_GRA | M_RIN, A_ADD);
    fetch("ld", 5'd0);
    push("ld_t3", 0, 5'd0, 0, 1, 1, M_GRB | M_BAOUT | M_YIN, A_ADD);
    push("ld_t4", 0, 5'd0, 0, 1, 1, M_COUT | M_ZIN, A_ADD);
    push("ld_t5", 0, 5'd0, 0, 1, 1, M_ZLO | M_MARIN, A_ADD);
    for (int i = 0; i < 3; i++)
      push("ld_t6_wait", 0, 5'd0, 0, 0, 1, M_READ | M_MDRIN, A_ADD);
    push("ld_t6_done", 0, 5'd0, 0, 1, 1, M_READ | M_MDRIN, A_ADD);
    push("ld_t7", 0, 5'd0, 0, 0, 1, M_MDROUT | M_GRA | M_RIN, A_ADD);
    fetch("ldi", 5'd1);
    push("ldi_t3", 0, 5'd1, 0, 1, 1, M_GRB | M_BAOUT | M_YIN, A_ADD);
    push("ldi_t4", 0, 5'd1, 0, 1, 1, M_COUT | M_ZIN, A_ADD);
    push("ldi_t5", 0, 5'd1, 0, 1, 1, M_ZLO | M_GRA | M_RIN, A_ADD);
    fetch("st", 5'd2);
    push("st_t3", 0, 5'd2, 0, 1, 1, M_GRB | M_BAOUT | M_YIN, A_ADD);
    push("st_t4", 0, 5'd2, 0, 1, 1, M_COUT | M_ZIN, A_ADD);
    push("st_t5", 0, 5'd2, 0, 1, 1, M_ZLO | M_MARIN, A_ADD);
    push("st_t6", 0, 5'd2, 0, 0, 1, M_GRA | M_ROUT | M_MDRIN, A_ADD);
    push("st_t7_wait", 0, 5'd2, 0, 0, 1, M_WRITE, A_ADD);
    push("st_t7_done", 0, 5'd2, 0, 1, 1, M_WRITE, A_ADD);
    for (int c = 0; c < 2; c++) begin
      fetch("br", 5'd19);
      push("br_t3", 0, 5'd19, c[0], 1, 1, M_GRA | M_ROUT | M_CONIN, A_ADD);
      push("br_t4", 0, 5'd19, c[0], 1, 1, M_PCOUT | M_YIN, A_ADD);
      push("br_t5", 0, 5'd19, c[0], 1, 1, M_COUT | M_ZIN, A_ADD);
      push(c ? "br_t6_taken" : "br_t6_not", 0, 5'd19, c[0], 1, 1,
           M_ZLO | (c ? M_PCIN : 27'd0), A_ADD);
    end
    fetch("jr", 5'd20);
    push("jr_t3", 0, 5'd20, 0, 1, 1, M_GRA | M_ROUT | M_PCIN, A_ADD);
    fetch("in", 5'd22);
    push("in_t3", 0, 5'd22, 0, 1, 1, M_INP | M_GRA | M_RIN, A_ADD);
    fetch("out", 5'd23);
    push("out_t3", 0, 5'd23, 0, 1, 1, M_GRA | M_ROUT | M_OUTP, A_ADD);
    fetch("mfhi", 5'd24);
    push("mfhi_t3", 0, 5'd24, 0, 1, 1, M_HIOUT | M_GRA | M_RIN, A_ADD);
    fetch("mflo", 5'd25);
    push("mflo_t3", 0, 5'd25, 0, 1, 1, M_LOOUT | M_GRA | M_RIN, A_ADD);
    fetch("nop", 5'd26);
    push("nop_t3", 0, 5'd26, 0, 1, 1, '0, A_ADD);
    fetch("undef", 5'd31);
    push("undef_t3", 0, 5'd31, 0, 1, 1, '0, A_ADD);
    fetch("halt", 5'd27);
    push("halt_t3", 0, 5'd27, 0, 1, 1, '0, A_ADD);
    for (int i = 0; i < 20; i++)
      push("halted", 0, 5'd27, 0, i[0], 0, '0, 5'd0);
    push("halt_clr", 1, 5'd27, 0, 1, 0, '0, 5'd0);
    push("halt_clr_fall", 0, 5'd3, 0, 1, 0, '0, 5'd0);
    push("resume_t0", 0, 5'd3, 0, 1, 1, T0_C, A_ADD);

    @(posedge clock);
    #1;
    for (int i = 0; i < tv.size(); i++)
      apply(tv[i]);

    // Clear arriving while the T1 fetch read is stalled.
    hv.nm = "wait_t1"; hv.clr = 0; hv.op = 5'd3; hv.con = 0; hv.md = 0;
    hv.run = 1; hv.ctl = T1_C; hv.alu = A_ADD;
    apply(hv);
    hv.nm = "wait_t1_clr"; hv.clr = 1;
    apply(hv);
    hv.nm = "after_clr"; hv.clr = 0; hv.run = 0; hv.ctl = '0; hv.alu = 0;
    apply(hv);
    hv.nm = "restart_t0"; hv.md = 1; hv.run = 1; hv.ctl = T0_C;
    hv.alu = A_ADD;
    apply(hv);
    hv.nm = "restart_t1"; hv.ctl = T1_C;
    apply(hv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore-style step sequencer for the Mini-SRC datapath.
- Issues the per-step register-select strobes (gra, grb, grc, r_in, r_out, ba_out) consumed by the register select/encode logic.
- Also issues all other bus, ALU and memory controls, stepping each instruction through fetch (T0-T2) and execute (T3-T7).
- Holds on memory handshakes and stops on halt.

Parameters:
- OPW, 5, opcode field width (ir[31:27]).
- STEPW, 3, step counter width (T0..T7).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, synchronous, active-high.
- ir  in  32  instruction register contents, stable from T3.
- con_ff  in  1  branch condition flag from the CON FF logic.
- mem_done  in  1  memory has completed the current read/write.
- run  out  1  high while executing, low in HALT/reset.
- gra, grb, grc  out  1 each  select Ra/Rb/Rc field for decode.
- r_in, r_out, ba_out  out  1 each  register file write / drive / base-address drive.
- c_out  out  1  drive sign-extended C onto the bus.
- pc_out, pc_in, inc_pc  out  1 each  PC controls.
- mar_in, mdr_in, mdr_out, ir_in, y_in, z_in  out  1 each  datapath register controls.
- zlow_out, zhigh_out, hi_in, lo_in, hi_out, lo_out  out  1 each  Z/HI/LO controls.
- con_in, inport_out, outport_in  out  1 each  CON FF and I/O controls.
- read, write  out  1 each  memory request, held until mem_done.
- alu_op  out  OPW  ALU operation code.

Behaviour:
- State: step counter (T0..T7) plus a HALT state.
- clear sampled high: next state T0, run=0, every control output 0. The cycle after clear falls is T0 with run=1. clear aborts any operation, including a pending memory wait.
- Outputs are a pure decode of registered state and ir.
- Every unasserted control is 0. alu_op = OP_ADD except where it is stated to be the opcode.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlow_out, pc_in, read, mdr_in.
  - T2: mdr_out, ir_in.
- Reg-reg (add, sub, and, or, shr, shra, shl, ror, rol), alu_op = opcode:
  - T3: grb, r_out, y_in.
  - T4: grc, r_out, z_in.
  - T5: zlow_out, gra, r_in.
- Immediate (addi, andi, ori), alu_op = opcode: same as reg-reg, except T4 uses c_out in place of grc and r_out.
- mul/div:
  - T3: gra, r_out, y_in.
  - T4: grb, r_out, z_in, alu_op = opcode.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in.
- neg/not:
  - T3: grb, r_out, z_in, alu_op = opcode.
  - T4: zlow_out, gra, r_in.
- ld:
  - T3: grb, ba_out, y_in.
  - T4: c_out, z_in.
  - T5: zlow_out, mar_in.
  - T6: read, mdr_in.
  - T7: mdr_out, gra, r_in.
- ldi: T3 and T4 as ld; T5: zlow_out, gra, r_in.
- st: T3-T5 as ld; T6: gra, r_out, mdr_in; T7: write.
- br:
  - T3: gra, r_out, con_in.
  - T4: pc_out, y_in.
  - T5: c_out, z_in.
  - T6: zlow_out; pc_in only if con_ff=1.
- jr: T3: gra, r_out, pc_in.
- in: T3: inport_out, gra, r_in.
- out: T3: gra, r_out, outport_in.
- mfhi: T3: hi_out, gra, r_in. mflo: T3: lo_out, gra, r_in.
- nop, and any undefined opcode: T3 is an idle step (all controls 0).
- Step advance:
  - After the last step of an instruction, next state is T0; no wrap beyond T7.
- Memory wait:
  - In any step asserting read or write, the step and all its outputs hold until mem_done=1 is sampled.
  - mem_done already high on entry gives a single-cycle step.
  - mem_done is ignored in steps that assert neither read nor write.
- halt:
  - T3 goes to HALT: run=0, all controls 0.
  - HALT is left only via clear.

Decomposition:
- Package sequencer_pkg holds:
  - the opcode constants (OP_LD=0 .. OP_HALT=27);
  - step encodings T0..T7 and HALT;
  - instruction-class enum (RR, IMM, MULDIV, UNARY, LD, LDI, ST, BR, JR, IN, OUT, MFHI, MFLO, NOP, HALT).
- Sub-module opcode_classifier maps ir[31:27] to an instruction class (combinational).
- The sequencer FSM consumes that class.

Test Plan:
- clear high 2 cycles, mem_done=1 -> all outputs 0, run=0; first cycle after clear: pc_out=mar_in=inc_pc=z_in=1, run=1.
- Fetch of add (ir[31:27]=3), mem_done=1 -> T1 read=1; T4 grc=r_out=z_in=1 with alu_op=3; T5 gra=r_in=zlow_out=1; the following cycle is T0.
- ld with mem_done held 0 for 3 cycles during T6 -> read=mdr_in stay 1 for 4 cycles, then T7 mdr_out=gra=r_in=1.
- br with con_ff=0 vs 1 -> T6 pc_in=0 vs 1; zlow_out=1 in both.
- halt (opcode 27) -> run=0 from T3 onward for 20 cycles despite mem_done toggling; then clear pulse -> T0 resumes.
- clear asserted during the T1 memory wait -> read drops to 0 the next cycle; sequence restarts at T0.
